// File: rtl/sec28_pkg.sv
// Shared constants and FSM encoding for the 28-bit SEC encoder/decoder pair.
// Keeping the generator and widths here makes both ends agree by construction.
package sec28_pkg;

    localparam int DATA_BITS = 28;
    localparam int CHK_BITS  = 8;
    localparam int W_BITS    = 36;

    // g(x) = x^8 + x^4 + x^3 + x^2 + 1, leading x^8 term implicit
    localparam logic [7:0] GEN_POLY = 8'h1D;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } sec_state_t;

endpackage

// File: rtl/sec_encoder_28bits_clk_if.sv
// Message-in / codeword-out handshake bundle of the bit-serial SEC encoder.
interface sec_encoder_28bits_clk_if
    import sec28_pkg::*;
#(
    parameter int DBITS = DATA_BITS,
    parameter int WBITS = W_BITS
) ();

    logic             in_valid;
    logic             in_ready;
    logic [DBITS-1:0] D;
    logic             err_en;
    logic [5:0]       err_pos;
    logic [WBITS-1:0] W;
    logic             out_valid;
    logic             out_ready;

    // Producer of messages and consumer of codewords
    modport master (
        output in_valid, D, err_en, err_pos, out_ready,
        input  in_ready, W, out_valid
    );

    // The encoder itself
    modport slave (
        input  in_valid, D, err_en, err_pos, out_ready,
        output in_ready, W, out_valid
    );

endinterface

// File: rtl/sec_lfsr8_step.sv
// One step of an 8-bit Galois LFSR dividing by a degree-8 generator.
// Shared with the decoder's syndrome computation.
module sec_lfsr8_step (
    input  logic [7:0] r,
    input  logic       din,
    input  logic [7:0] poly,
    output logic [7:0] r_next
);

    logic fb;

    // Feedback is the incoming bit xor the bit about to leave x^7
    always_comb begin
        fb     = din ^ r[7];
        r_next = {r[6:0], 1'b0} ^ (fb ? poly : 8'h00);
    end

endmodule

// File: rtl/sec_encoder_28bits_clk.sv
// Bit-serial systematic encoder: W = {D, D*x^8 mod g}, MSB of D first,
// one data bit per clock, with optional single-bit error injection.
//
// state    | meaning
// ST_IDLE  | ready for a new message
// ST_SHIFT | feeding D[cnt] into the LFSR, cnt 27 down to 0
// ST_DONE  | codeword presented, waiting for out_ready
module sec_encoder_28bits_clk
    import sec28_pkg::*;
#(
    parameter int         DATA_BITS = sec28_pkg::DATA_BITS,
    parameter int         CHK_BITS  = sec28_pkg::CHK_BITS,
    parameter int         W_BITS    = sec28_pkg::W_BITS,
    parameter logic [7:0] GEN_POLY  = sec28_pkg::GEN_POLY
) (
    input  logic                    clk,
    input  logic                    rst_n,
    sec_encoder_28bits_clk_if.slave bus
);

    sec_state_t            state;
    logic                  in_ready_q;
    logic                  out_valid_q;
    logic [W_BITS-1:0]     w_q;
    logic [CHK_BITS-1:0]   r;
    logic [CHK_BITS-1:0]   r_next;
    logic [4:0]            cnt;
    logic [DATA_BITS-1:0]  d_lat;
    logic                  err_en_lat;
    logic [5:0]            err_pos_lat;
    logic [W_BITS-1:0]     flip;

    sec_lfsr8_step u_step (
        .r      (r),
        .din    (d_lat[cnt]),
        .poly   (GEN_POLY),
        .r_next (r_next)
    );

    // Injection mask; out-of-range positions leave the codeword untouched
    always_comb begin
        flip = '0;
        if (err_en_lat && (err_pos_lat < 6'(W_BITS)))
            flip[err_pos_lat] = 1'b1;
    end

    // Sequencer: accept, shift 28 data bits, hold codeword until handoff
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            w_q         <= '0;
            r           <= '0;
            cnt         <= '0;
            d_lat       <= '0;
            err_en_lat  <= 1'b0;
            err_pos_lat <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        d_lat       <= bus.D;
                        err_en_lat  <= bus.err_en;
                        err_pos_lat <= bus.err_pos;
                        r           <= '0;
                        cnt         <= 5'(DATA_BITS - 1);
                        in_ready_q  <= 1'b0;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r <= r_next;
                    if (cnt == 5'd0) begin
                        // Final remainder goes straight into W on the same edge
                        w_q         <= {d_lat, r_next} ^ flip;
                        out_valid_q <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.W         = w_q;

endmodule

// File: tb/tb_sec_encoder_28bits_clk.sv
// Self-checking bench for sec_encoder_28bits_clk: fixed vectors, backpressure,
// reset abort, and a random loopback through a reference SEC decoder model.
module tb_sec_encoder_28bits_clk;
    import sec28_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    sec_encoder_28bits_clk_if bus ();

    sec_encoder_28bits_clk dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Polynomial remainder of v(x) modulo the full generator x^8+x^4+x^3+x^2+1
    function automatic logic [7:0] poly_mod(input logic [35:0] v);
        logic [35:0] m;
        m = v;
        for (int i = 35; i >= 8; i--)
            if (m[i]) m = m ^ (36'h11D << (i - 8));
        return m[7:0];
    endfunction

    function automatic logic [35:0] ref_encode(input logic [27:0] d, input logic en,
                                               input logic [5:0] pos);
        logic [35:0] w;
        w = {d, poly_mod({d, 8'h00})};
        if (en && pos < 6'd36) w = w ^ (36'd1 << pos);
        return w;
    endfunction

    // Syndrome lookup decoder: x^i mod g is distinct for i < 255 (g primitive)
    function automatic logic [27:0] ref_decode(input logic [35:0] w_in);
        logic [35:0] w;
        logic [7:0]  syn;
        w   = w_in;
        syn = poly_mod(w);
        if (syn != 8'h00) begin
            for (int i = 0; i < 36; i++) begin
                if (poly_mod(36'd1 << i) == syn) begin
                    w = w ^ (36'd1 << i);
                    break;
                end
            end
        end
        return w[35:8];
    endfunction

    // Present one message, then wait (bounded) for out_valid; lat counts edges after accept
    task automatic run_txn(input logic [27:0] d, input logic en, input logic [5:0] pos,
                           output int lat);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.D        = d;
        bus.err_en   = en;
        bus.err_pos  = pos;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.D        = 28'($urandom);
        bus.err_en   = 1'($urandom);
        bus.err_pos  = 6'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.W !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b W=%h, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.W);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.W !== 36'd0) begin
            n_fail++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b W=%h, want 1 0 0",
                     bus.in_ready, bus.out_valid, bus.W);
        end
    endtask

    task automatic test_known_vectors();
        logic [27:0] d_t   [6] = '{28'd0, 28'd1, 28'd2, 28'd1, 28'd1, 28'd1};
        logic        en_t  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [5:0]  pos_t [6] = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd35, 6'd40};
        logic [35:0] exp_t [6] = '{36'd0, 36'd285, 36'd570, 36'd284,
                                   36'h80000011D, 36'd285};
        int lat;
        for (int i = 0; i < 6; i++) begin
            run_txn(d_t[i], en_t[i], pos_t[i], lat);
            n_tests++;
            if (lat != 28) begin
                n_fail++;
                $display("FAIL latency[%0d]: got %0d clocks, want 28", i, lat);
            end
            n_tests++;
            if (bus.W !== exp_t[i]) begin
                n_fail++;
                $display("FAIL known_w[%0d]: W=%h, want %h", i, bus.W, exp_t[i]);
            end
            handoff();
            n_tests++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL handoff[%0d]: out_valid=%b in_ready=%b, want 0 1",
                         i, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int bad;
        run_txn(28'd1, 1'b0, 6'd0, lat);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.W !== 36'd285 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) bad++;
            bus.in_valid = (k == 4);
            bus.D        = 28'd2;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_tests++;
        if (lat != 28 || bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: lat=%0d bad_cycles=%0d, want 28 0", lat, bad);
        end
        handoff();
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.W !== 36'd285) begin
            n_fail++;
            $display("FAIL stall_release: in_ready=%b out_valid=%b W=%h, want 1 0 11d",
                     bus.in_ready, bus.out_valid, bus.W);
        end
        bad = 0;
        repeat (35) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_pulse_ignored: %0d cycles busy, want 0", bad);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.D        = 28'h5A5A5A5;
        bus.err_en   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.W !== 36'd0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_shift: out_valid=%b W=%h in_ready=%b, want 0 0 1",
                     bus.out_valid, bus.W, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_txn(28'd2, 1'b0, 6'd0, lat);
        n_tests++;
        if (lat != 28 || bus.W !== 36'd570) begin
            n_fail++;
            $display("FAIL after_abort: lat=%0d W=%h, want 28 23a", lat, bus.W);
        end
        // Reset while the codeword is being presented
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_done: out_valid=%b in_ready=%b, want 0 1",
                     bus.out_valid, bus.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loopback();
        int          lat;
        int          bad_w;
        int          bad_d;
        logic [27:0] d;
        logic        en;
        logic [5:0]  pos;
        logic [35:0] exp_w;
        bad_w = 0;
        bad_d = 0;
        for (int i = 0; i < 1000; i++) begin
            d     = 28'($urandom);
            en    = ($urandom_range(0, 3) != 0);
            pos   = 6'($urandom_range(0, 40));
            exp_w = ref_encode(d, en, pos);
            run_txn(d, en, pos, lat);
            n_tests++;
            if (lat != 28 || bus.W !== exp_w) begin
                n_fail++;
                bad_w++;
                if (bad_w <= 5)
                    $display("FAIL loop_w[%0d]: D=%h en=%b pos=%0d lat=%0d W=%h, want %h",
                             i, d, en, pos, lat, bus.W, exp_w);
            end
            n_tests++;
            if (ref_decode(bus.W) !== d) begin
                n_fail++;
                bad_d++;
                if (bad_d <= 5)
                    $display("FAIL loop_decode[%0d]: recovered %h, want %h",
                             i, ref_decode(bus.W), d);
            end
            if (lat >= 100) return;
            handoff();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.D         = '0;
        bus.err_en    = 1'b0;
        bus.err_pos   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_known_vectors();
        test_backpressure();
        test_reset_abort();
        test_loopback();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/sec_encoder_28bits_clk.md
# sec_encoder_28bits_clk

Bit-serial systematic encoder for the team's 28-bit single-error-correcting (SEC) cyclic code. It sits directly upstream of the clocked 28-bit SEC decoder and produces the 36-bit codeword `W` that the decoder consumes. It computes 8 check bits over 28 data bits with an LFSR, one data bit per clock. An optional single-bit error injection stage lets the decoder be exercised end to end.

## Interface
Parameters:
- `DATA_BITS`, 28, message width.
- `CHK_BITS`, 8, check width; generator degree.
- `W_BITS`, 36, codeword width; must equal `DATA_BITS + CHK_BITS`.
- `GEN_POLY`, 8'h1D, generator g(x)=x^8+x^4+x^3+x^2+1, leading x^8 term implicit.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `D`/`err_en`/`err_pos` valid.
- `in_ready`  out  1  encoder idle, can accept.
- `D`  in  28  message data.
- `err_en`  in  1  inject a single-bit error into this codeword.
- `err_pos`  in  6  bit index of `W` to flip.
- `W`  out  36  codeword, `{data, check}`.
- `out_valid`  out  1  `W` valid.
- `out_ready`  in  1  downstream (decoder) accepts `W`.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`: latch `D`, `err_en`, `err_pos`; clear remainder `r` to 0; set bit counter to 27; go to SHIFT.
- SHIFT:
  - Each cycle consumes data bit `D[cnt]`, MSB first.
  - `fb = D[cnt] ^ r[7]`; `r <= {r[6:0],1'b0} ^ (fb ? GEN_POLY : 0)`.
  - `cnt` decrements. After the `cnt==0` step, go to DONE.
- Entry to DONE:
  - Register `W = {D_latched, r_final}` in the same edge as the last step.
  - If `err_en_latched` and `err_pos < 36`, flip `W[err_pos]`.
  - If `err_pos >= 36`, no bit is flipped.
- DONE:
  - `out_valid`=1 and `W` stable until `out_valid & out_ready`.
  - After that handshake, go to IDLE.
- `W` retains its last value in IDLE/SHIFT. `W` only changes on entry to DONE.
- `in_valid` while `in_ready`=0 is ignored, with no queuing.
- `D`, `err_en` and `err_pos` may change after acceptance without effect.
- Check arithmetic is modulo-2 only. `r` is exactly 8 bits. The counter is 5 bits and never wraps below 0.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `W`=0, `r`=0, counter=0.
- Acceptance at edge E0. Shift steps at E1..E28. `out_valid` rises after E28, so latency is 28 clocks.
- Handoff edge Eh (`out_valid & out_ready`): after Eh, `out_valid`=0 and `in_ready`=1.
- No accept in the Eh cycle. Minimum issue interval is 30 clocks.
- `out_ready` high before DONE has no effect. Backpressure is unbounded.
- `rst_n` low mid-SHIFT or in DONE aborts asynchronously:
  - `out_valid` drops immediately.
  - No partial codeword is ever presented.
  - The next transaction after reset is encoded correctly.

## Structure
- Shared package `sec28_pkg` holds:
  - `DATA_BITS`, `CHK_BITS`, `W_BITS`, `GEN_POLY`.
  - FSM state enum (IDLE/SHIFT/DONE).
  - The decoder includes the same package, so generator and widths match by construction.
- One sub-module, `sec_lfsr8_step`, combinational: `(r, din, poly) -> r_next`.
  - The decoder's syndrome LFSR reuses it.
- Top module holds the FSM, counter, latches, injection and output register.

## Test plan
- Reset, then D=0, no error:
  - `out_valid` rises 28 clocks after accept.
  - W=0.
- D=1, no error -> W=0x11D (285).
- D=2, no error -> W=0x23A (570), confirming the x^9 mod g reduction.
- D=1, `err_en`=1:
  - `err_pos`=0 -> W=0x11C (284).
  - `err_pos`=35 -> W=0x80000011D.
  - `err_pos`=40 -> W=285, no flip.
- D=1 with `out_ready` held low 10 cycles after `out_valid`:
  - W stays 285.
  - `in_ready`=0 throughout.
  - A second `in_valid` pulse during the stall is ignored.
  - After `out_ready`, `in_ready`=1 the next cycle.
- Reset asserted 10 cycles into SHIFT:
  - `out_valid` stays 0, W=0, `in_ready`=1.
  - A following D=2 encode yields W=570.
- Loopback:
  - Feed 1000 random D with random single-bit injections into the SEC decoder.
  - The decoder must recover D for every vector.
